// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin arbiter sharing the single-port data_mem
// between the core load/store path (port 0) and the debug/DMA path (port 1).
// Ports:
//   Clk_Core, Rst_Core_N          clock, synchronous active-low reset
//   ReqN_Valid/Ready/Addr/Wdata/Wstrb  request handshake per port (Wstrb=0 is a read)
//   RspN_Valid/Rdata/Err          registered one-cycle response per port
//   Read_Ctrl, Write_Ctrl, Mem_Data_Address, Mem_Data_Write  to data_mem
//   Mem_Data_Read                 from data_mem, valid the cycle after Read_Ctrl
module data_mem_arbiter #(
    parameter int unsigned MEM_SIZE = 256
) (
    input  logic        Clk_Core,
    input  logic        Rst_Core_N,
    input  logic        Req0_Valid,
    output logic        Req0_Ready,
    input  logic [31:0] Req0_Addr,
    input  logic [31:0] Req0_Wdata,
    input  logic [3:0]  Req0_Wstrb,
    input  logic        Req1_Valid,
    output logic        Req1_Ready,
    input  logic [31:0] Req1_Addr,
    input  logic [31:0] Req1_Wdata,
    input  logic [3:0]  Req1_Wstrb,
    output logic        Rsp0_Valid,
    output logic [31:0] Rsp0_Rdata,
    output logic        Rsp0_Err,
    output logic        Rsp1_Valid,
    output logic [31:0] Rsp1_Rdata,
    output logic        Rsp1_Err,
    output logic        Read_Ctrl,
    output logic [3:0]  Write_Ctrl,
    output logic [31:0] Mem_Data_Address,
    output logic [31:0] Mem_Data_Write,
    input  logic [31:0] Mem_Data_Read
);

    localparam int unsigned ADDR_SIZE = $clog2(MEM_SIZE);
    localparam int unsigned TAG_LSB   = ADDR_SIZE + 2;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    typedef enum logic {
        IDLE,
        RD_WAIT
    } state_t;

    state_t      state, state_nxt;
    logic        last_grant;
    logic        owner;
    req_t        req [2];
    req_t        sel_req;
    logic        gnt_valid;
    logic        gnt_sel;
    logic        sel_in_range;
    logic [1:0]  rsp_valid_q;
    logic [1:0]  rsp_err_q;
    logic [31:0] rsp_rdata_q [2];

    assign req[0] = '{addr: Req0_Addr, wdata: Req0_Wdata, wstrb: Req0_Wstrb};
    assign req[1] = '{addr: Req1_Addr, wdata: Req1_Wdata, wstrb: Req1_Wstrb};

    // Arbitration, memory drive and next state; Ready is held low during reset.
    always_comb begin
        state_nxt        = state;
        gnt_valid        = 1'b0;
        gnt_sel          = 1'b0;
        sel_req          = req[0];
        sel_in_range     = 1'b0;
        Req0_Ready       = 1'b0;
        Req1_Ready       = 1'b0;
        Read_Ctrl        = 1'b0;
        Write_Ctrl       = 4'b0000;
        Mem_Data_Address = 32'd0;
        Mem_Data_Write   = 32'd0;
        case (state)
            IDLE: begin
                if (Rst_Core_N && (Req0_Valid || Req1_Valid)) begin
                    gnt_valid    = 1'b1;
                    // With both pending, the port that did not win last time goes.
                    gnt_sel      = (Req0_Valid && Req1_Valid) ? ~last_grant : Req1_Valid;
                    sel_req      = req[gnt_sel];
                    sel_in_range = (sel_req.addr[31:TAG_LSB] == '0);
                    Req0_Ready   = ~gnt_sel;
                    Req1_Ready   = gnt_sel;
                    if (sel_in_range) begin
                        Mem_Data_Address = sel_req.addr;
                        if (sel_req.wstrb != 4'b0000) begin
                            Write_Ctrl     = sel_req.wstrb;
                            Mem_Data_Write = sel_req.wdata;
                        end else begin
                            Read_Ctrl = 1'b1;
                            state_nxt = RD_WAIT;
                        end
                    end
                end
            end
            RD_WAIT: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, grant history and registered responses.
    always_ff @(posedge Clk_Core) begin
        if (!Rst_Core_N) begin
            state          <= IDLE;
            last_grant     <= 1'b1;
            owner          <= 1'b0;
            rsp_valid_q    <= 2'b00;
            rsp_err_q      <= 2'b00;
            rsp_rdata_q[0] <= 32'd0;
            rsp_rdata_q[1] <= 32'd0;
        end else begin
            state       <= state_nxt;
            rsp_valid_q <= 2'b00;
            if (gnt_valid) begin
                last_grant <= gnt_sel;
                if (sel_in_range && (sel_req.wstrb == 4'b0000)) begin
                    owner <= gnt_sel;
                end else begin
                    // Writes and range errors answer next cycle without read data.
                    rsp_valid_q[gnt_sel] <= 1'b1;
                    rsp_rdata_q[gnt_sel] <= 32'd0;
                    rsp_err_q[gnt_sel]   <= ~sel_in_range;
                end
            end
            if (state == RD_WAIT) begin
                rsp_valid_q[owner] <= 1'b1;
                rsp_rdata_q[owner] <= Mem_Data_Read;
                rsp_err_q[owner]   <= 1'b0;
            end
        end
    end

    assign Rsp0_Valid = rsp_valid_q[0];
    assign Rsp1_Valid = rsp_valid_q[1];
    assign Rsp0_Err   = rsp_err_q[0];
    assign Rsp1_Err   = rsp_err_q[1];
    assign Rsp0_Rdata = rsp_rdata_q[0];
    assign Rsp1_Rdata = rsp_rdata_q[1];

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed bench for data_mem_arbiter with a behavioural
// data_mem, a reference memory and per-port response scoreboards.
module tb_data_mem_arbiter;

    localparam int unsigned MEM_SIZE = 256;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    logic        Clk_Core = 1'b0;
    logic        Rst_Core_N;
    logic [1:0]  vld;
    logic [31:0] ra [2];
    logic [31:0] rwd [2];
    logic [3:0]  rws [2];
    logic        Req0_Ready, Req1_Ready;
    logic        Rsp0_Valid, Rsp1_Valid, Rsp0_Err, Rsp1_Err;
    logic [31:0] Rsp0_Rdata, Rsp1_Rdata;
    logic        Read_Ctrl;
    logic [3:0]  Write_Ctrl;
    logic [31:0] Mem_Data_Address, Mem_Data_Write;
    logic [31:0] Mem_Data_Read;

    logic [31:0] mem     [MEM_SIZE] = '{default: 32'd0};
    logic [31:0] ref_mem [MEM_SIZE] = '{default: 32'd0};
    exp_t        q0 [$];
    exp_t        q1 [$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_err = 0;

    logic [1:0]  rdy, rv, rerr;
    logic [31:0] rrd [2];

    assign rdy    = {Req1_Ready, Req0_Ready};
    assign rv     = {Rsp1_Valid, Rsp0_Valid};
    assign rerr   = {Rsp1_Err, Rsp0_Err};
    assign rrd[0] = Rsp0_Rdata;
    assign rrd[1] = Rsp1_Rdata;

    data_mem_arbiter #(.MEM_SIZE(MEM_SIZE)) dut (
        .Clk_Core(Clk_Core), .Rst_Core_N(Rst_Core_N),
        .Req0_Valid(vld[0]), .Req0_Ready(Req0_Ready), .Req0_Addr(ra[0]),
        .Req0_Wdata(rwd[0]), .Req0_Wstrb(rws[0]),
        .Req1_Valid(vld[1]), .Req1_Ready(Req1_Ready), .Req1_Addr(ra[1]),
        .Req1_Wdata(rwd[1]), .Req1_Wstrb(rws[1]),
        .Rsp0_Valid(Rsp0_Valid), .Rsp0_Rdata(Rsp0_Rdata), .Rsp0_Err(Rsp0_Err),
        .Rsp1_Valid(Rsp1_Valid), .Rsp1_Rdata(Rsp1_Rdata), .Rsp1_Err(Rsp1_Err),
        .Read_Ctrl(Read_Ctrl), .Write_Ctrl(Write_Ctrl),
        .Mem_Data_Address(Mem_Data_Address), .Mem_Data_Write(Mem_Data_Write),
        .Mem_Data_Read(Mem_Data_Read)
    );

    always #5 Clk_Core = ~Clk_Core;

    always @(posedge Clk_Core) cyc <= cyc + 1;

    // Behavioural data_mem: byte-enabled write, one-cycle registered read.
    always @(posedge Clk_Core) begin
        for (int b = 0; b < 4; b++)
            if (Write_Ctrl[b]) mem[Mem_Data_Address[9:2]][8*b +: 8] <= Mem_Data_Write[8*b +: 8];
        if (Read_Ctrl) Mem_Data_Read <= mem[Mem_Data_Address[9:2]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference result for a request accepted at the coming edge.
    function automatic exp_t model(input int p);
        exp_t e;
        logic [7:0] idx;
        idx = ra[p][9:2];
        if (ra[p][31:10] != 22'd0) begin
            e = '{rdata: 32'd0, err: 1'b1, due: cyc + 1};
        end else if (rws[p] != 4'b0000) begin
            for (int b = 0; b < 4; b++)
                if (rws[p][b]) ref_mem[idx][8*b +: 8] = rwd[p][8*b +: 8];
            e = '{rdata: 32'd0, err: 1'b0, due: cyc + 1};
        end else begin
            e = '{rdata: ref_mem[idx], err: 1'b0, due: cyc + 2};
        end
        return e;
    endfunction

    // Scoreboard: check responses, then record expectations for accepts.
    task automatic monitor();
        exp_t e;
        bit   have;
        forever begin
            @(negedge Clk_Core);
            if (!Rst_Core_N) begin
                q0.delete();
                q1.delete();
            end else begin
                for (int p = 0; p < 2; p++) begin
                    if (rv[p]) begin
                        have = (p == 0) ? (q0.size() > 0) : (q1.size() > 0);
                        chk($sformatf("rsp%0d_expected", p), 32'(have), 32'd1);
                        if (have) begin
                            if (p == 0) e = q0.pop_front();
                            else        e = q1.pop_front();
                            chk($sformatf("rsp%0d_rdata", p), rrd[p], e.rdata);
                            chk($sformatf("rsp%0d_err", p), 32'(rerr[p]), 32'(e.err));
                            chk($sformatf("rsp%0d_cycle", p), 32'(cyc), 32'(e.due));
                        end
                    end
                end
                chk("one_hot_ready", 32'(rdy == 2'b11), 32'd0);
                for (int p = 0; p < 2; p++) begin
                    if (vld[p] && rdy[p]) begin
                        e = model(p);
                        if (p == 0) q0.push_back(e);
                        else        q1.push_back(e);
                    end
                end
            end
        end
    endtask

    task automatic wait_accept(input int p);
        bit ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge Clk_Core);
            ok = rdy[p];
        end
        chk($sformatf("accept_p%0d", p), 32'(ok), 32'd1);
        @(posedge Clk_Core);
        #1 vld[p] = 1'b0;
    endtask

    task automatic req(input int p, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
        vld[p] = 1'b1;
        ra[p]  = a;
        rwd[p] = wd;
        rws[p] = ws;
        wait_accept(p);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ready"}, 32'(rdy), 32'd0);
        chk({tag, "_rd_ctrl"}, 32'(Read_Ctrl), 32'd0);
        chk({tag, "_wr_ctrl"}, 32'(Write_Ctrl), 32'd0);
        chk({tag, "_maddr"}, Mem_Data_Address, 32'd0);
        chk({tag, "_mwdata"}, Mem_Data_Write, 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rv), 32'd0);
        chk({tag, "_rsp_err"}, 32'(rerr), 32'd0);
        chk({tag, "_rdata0"}, rrd[0], 32'd0);
        chk({tag, "_rdata1"}, rrd[1], 32'd0);
    endtask

    task automatic settle();
        repeat (3) @(posedge Clk_Core);
        @(negedge Clk_Core);
        chk("idle_ready", 32'(rdy), 32'd0);
        chk("idle_rd_ctrl", 32'(Read_Ctrl), 32'd0);
        chk("idle_wr_ctrl", 32'(Write_Ctrl), 32'd0);
        chk("idle_maddr", Mem_Data_Address, 32'd0);
        chk("idle_mwdata", Mem_Data_Write, 32'd0);
        @(posedge Clk_Core);
        #1;
    endtask

    task automatic do_reset();
        @(posedge Clk_Core);
        #1 Rst_Core_N = 1'b0;
        vld = 2'b00;
        repeat (2) @(posedge Clk_Core);
        @(negedge Clk_Core);
        chk_quiet("reset");
        @(posedge Clk_Core);
        #1 Rst_Core_N = 1'b1;
    endtask

    initial begin
        Rst_Core_N = 1'b0;
        vld = 2'b00;
        for (int p = 0; p < 2; p++) begin
            ra[p] = 32'd0; rwd[p] = 32'd0; rws[p] = 4'd0;
        end
        fork monitor(); join_none
        repeat (3) @(posedge Clk_Core);
        @(negedge Clk_Core);
        chk_quiet("por");
        @(posedge Clk_Core);
        #1 Rst_Core_N = 1'b1;

        // Port 0 write then back-to-back read of the same word.
        req(0, 32'h10, 32'hDEADBEEF, 4'hF);
        req(0, 32'h10, 32'h0, 4'h0);
        settle();

        // Partial write from port 1 over a known pattern, read back on port 0.
        req(1, 32'h20, 32'hAAAAAAAA, 4'hF);
        req(1, 32'h20, 32'h11223344, 4'b0101);
        req(0, 32'h20, 32'h0, 4'h0);
        settle();

        // Out-of-range read never reaches the memory.
        vld[0] = 1'b1; ra[0] = 32'h400; rws[0] = 4'h0;
        @(negedge Clk_Core);
        chk("oor_ready", 32'(Req0_Ready), 32'd1);
        chk("oor_rd_ctrl", 32'(Read_Ctrl), 32'd0);
        chk("oor_wr_ctrl", 32'(Write_Ctrl), 32'd0);
        @(posedge Clk_Core);
        #1 vld[0] = 1'b0;
        @(negedge Clk_Core);
        chk("oor_rd_ctrl_after", 32'(Read_Ctrl), 32'd0);
        chk("oor_wr_ctrl_after", 32'(Write_Ctrl), 32'd0);
        settle();

        // Contention from reset: continuous reads on both ports.
        do_reset();
        vld = 2'b11;
        ra[0] = 32'h0; ra[1] = 32'h4; rws[0] = 4'h0; rws[1] = 4'h0;
        for (int k = 0; k < 8; k++) begin
            @(negedge Clk_Core);
            chk($sformatf("cont_ready0_k%0d", k), 32'(Req0_Ready), 32'((k % 4) == 0));
            chk($sformatf("cont_ready1_k%0d", k), 32'(Req1_Ready), 32'((k % 4) == 2));
        end
        @(posedge Clk_Core);
        #1 vld = 2'b00;
        settle();

        // Reset while a read is outstanding: response is discarded.
        vld[0] = 1'b1; ra[0] = 32'h10; rws[0] = 4'h0;
        @(negedge Clk_Core);
        chk("rdwait_ready0", 32'(Req0_Ready), 32'd1);
        @(posedge Clk_Core);
        #1 vld[0] = 1'b0;
        Rst_Core_N = 1'b0;
        @(posedge Clk_Core);
        @(negedge Clk_Core);
        chk_quiet("rst_rdwait");
        vld = 2'b11;
        ra[0] = 32'h30; rwd[0] = 32'hCAFEF00D; rws[0] = 4'hF;
        ra[1] = 32'h30; rwd[1] = 32'h0;        rws[1] = 4'h0;
        @(negedge Clk_Core);
        chk_quiet("rst_hold");
        @(posedge Clk_Core);
        #1 Rst_Core_N = 1'b1;
        @(negedge Clk_Core);
        chk("post_rst_ready0", 32'(Req0_Ready), 32'd1);
        chk("post_rst_ready1", 32'(Req1_Ready), 32'd0);
        @(posedge Clk_Core);
        #1 vld[0] = 1'b0;
        wait_accept(1);

        repeat (6) @(negedge Clk_Core);
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
